// File: rtl/booth_radix4_sequencer.sv
// Sequential radix-4 Booth multiplier that retires two multiplier bits per clock over WIDTH/2 steps.
// Define BOOTH_OVERFLOW_DETECT_EN to drive data_exception from signed-overflow detection; otherwise it is tied low.
module booth_radix4_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH+1:0] acc, acc_next, partial, m_ext, sum;
    logic [WIDTH-1:0] m, q, q_next;
    logic             q_low, q_low_next;
    logic [CW-1:0]    count;
    logic             last_step;
    logic             step_en;

    // ACC is two bits wider than the operands, so adding +/-2M cannot overflow it.
    assign m_ext = {{2{m[WIDTH-1]}}, m};

    always_comb begin
        partial = '0;
        case ({q[1:0], q_low})
            3'b001, 3'b010: partial = m_ext;
            3'b011:         partial = m_ext << 1;
            3'b100:         partial = -(m_ext << 1);
            3'b101, 3'b110: partial = -m_ext;
            default:        partial = '0;
        endcase
    end

    assign sum        = acc + partial;
    assign acc_next   = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
    assign q_next     = {sum[1:0], q[WIDTH-1:2]};
    assign q_low_next = q[1];
    assign last_step  = (count == CW'(STEPS - 1));
    assign step_en    = (state == RUN) && !ctrl_MULT && !ctrl_DIV;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: state_next = IDLE;
            RUN: begin
                if (ctrl_DIV) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A start request wins from any state, including over an abort.
        if (ctrl_MULT) begin
            state_next = RUN;
        end
    end

    assign busy           = (state == RUN);
    assign data_resultRDY = (state == DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m           <= '0;
            q           <= '0;
            acc         <= '0;
            q_low       <= 1'b0;
            count       <= '0;
            data_result <= '0;
        end else if (ctrl_MULT) begin
            m     <= data_operandA;
            q     <= data_operandB;
            acc   <= '0;
            q_low <= 1'b0;
            count <= '0;
        end else if (step_en) begin
            acc   <= acc_next;
            q     <= q_next;
            q_low <= q_low_next;
            count <= count + CW'(1);
            if (last_step) begin
                data_result <= q_next;
            end
        end
    end

`ifdef BOOTH_OVERFLOW_DETECT_EN
    logic exception_reg;

    // The full product is {acc_next[WIDTH-1:0], q_next}; overflow when its upper half is not a pure sign extension.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            exception_reg <= 1'b0;
        end else if (step_en && last_step) begin
            exception_reg <= (acc_next[WIDTH-1:0] != {WIDTH{q_next[WIDTH-1]}});
        end
    end

    assign data_exception = exception_reg;
`else
    assign data_exception = 1'b0;
`endif

endmodule

// File: tb/tb_booth_radix4_sequencer.sv
// Directed self-checking bench for booth_radix4_sequencer at WIDTH=32.
// Exception expectations follow whether BOOTH_OVERFLOW_DETECT_EN is defined for the build.
module tb_booth_radix4_sequencer;

    localparam int WIDTH = 32;
`ifdef BOOTH_OVERFLOW_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    int total = 0;
    int bad   = 0;

    booth_radix4_sequencer #(.WIDTH(WIDTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    localparam int NVEC = 13;
    logic [31:0] vec_a   [NVEC] = '{32'd7, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'd123,
                                    32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFB, 32'h00000000,
                                    32'h80000000, 32'hFFFF0000, 32'h12345678, 32'hFFFFFFFF};
    logic [31:0] vec_b   [NVEC] = '{32'hFFFFFFFD, 32'd2, 32'hFFFFFFFF, 32'd1, 32'd456,
                                    32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFF9, 32'h12345678,
                                    32'h80000000, 32'h00010000, 32'h00000010, 32'h80000000};
    logic [31:0] vec_res [NVEC] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h80000000, 32'h80000000, 32'h0000DB18,
                                    32'h00000001, 32'h00000000, 32'h00000023, 32'h00000000,
                                    32'h00000000, 32'h00000000, 32'h23456780, 32'h80000000};
    logic        vec_ovf [NVEC] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                                    1'b0, 1'b1, 1'b0, 1'b0,
                                    1'b1, 1'b1, 1'b1, 1'b1};

    // Pulses ctrl_MULT for one edge, then waits (bounded) for the completion strobe.
    task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                            output int latency, output logic [31:0] res, output logic exc);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        latency   = -1;
        res       = '0;
        exc       = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin
                latency = i;
                res     = data_result;
                exc     = data_exception;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = 32'd3; data_operandB = 32'd3;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
            bad++; $display("[TB] FAIL reset_outputs got=%h required=0", {data_result, data_exception, data_resultRDY, busy});
        end
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        total++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
            bad++; $display("[TB] FAIL reset_idle busy=%b rdy=%b required 0 0", busy, data_resultRDY);
        end
    endtask

    task automatic test_basic();
        int busy_bad = 0;
        data_operandA = 32'd7; data_operandB = 32'hFFFFFFFD; ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (busy !== 1'b1 || data_resultRDY !== 1'b0) busy_bad++;
            @(posedge clock); #1;
        end
        total++;
        if (busy_bad != 0) begin
            bad++; $display("[TB] FAIL basic_busy_window bad_cycles=%0d required=0", busy_bad);
        end
        total++;
        if (data_resultRDY !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_rdy_at_16 rdy=%b busy=%b required 1 0", data_resultRDY, busy);
        end
        total++;
        if (data_result !== 32'hFFFFFFEB || data_exception !== 1'b0) begin
            bad++; $display("[TB] FAIL basic_result got=%h/%b required=FFFFFFEB/0", data_result, data_exception);
        end
        @(posedge clock); #1;
        total++;
        if (data_resultRDY !== 1'b0 || data_result !== 32'hFFFFFFEB) begin
            bad++; $display("[TB] FAIL basic_rdy_one_cycle rdy=%b res=%h required 0 FFFFFFEB", data_resultRDY, data_result);
        end
    endtask

    task automatic test_products();
        int lat; logic [31:0] res; logic exc;
        for (int v = 0; v < NVEC; v++) begin
            run_mult(vec_a[v], vec_b[v], lat, res, exc);
            total++;
            if (lat != 16) begin
                bad++; $display("[TB] FAIL product%0d_latency got=%0d required=16", v, lat);
            end
            total++;
            if (res !== vec_res[v]) begin
                bad++; $display("[TB] FAIL product%0d_result got=%h required=%h", v, res, vec_res[v]);
            end
            total++;
            if (exc !== (vec_ovf[v] & OVF_EN)) begin
                bad++; $display("[TB] FAIL product%0d_exception got=%b required=%b", v, exc, vec_ovf[v] & OVF_EN);
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_restart();
        int pulses = 0; int first = -1; logic [31:0] res = '0;
        data_operandA = 32'd5; data_operandB = 32'd5; ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        data_operandA = 32'd6; data_operandB = 32'hFFFFFFFA; ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin
                pulses++;
                if (first < 0) begin first = i; res = data_result; end
            end
        end
        total++;
        if (pulses != 1 || first != 16) begin
            bad++; $display("[TB] FAIL restart_strobe pulses=%0d at=%0d required 1 at 16", pulses, first);
        end
        total++;
        if (res !== 32'hFFFFFFDC) begin
            bad++; $display("[TB] FAIL restart_result got=%h required=FFFFFFDC", res);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0; int lat; logic [31:0] res; logic exc;
        data_operandA = 32'd9; data_operandB = 32'd9; ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (8) begin @(posedge clock); #1; end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
            bad++; $display("[TB] FAIL midreset_outputs got=%h required=0", {data_result, data_exception, data_resultRDY, busy});
        end
        #2 reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++; $display("[TB] FAIL midreset_no_rdy pulses=%0d required=0", pulses);
        end
        run_mult(32'd9, 32'd9, lat, res, exc);
        total++;
        if (lat != 16 || res !== 32'd81) begin
            bad++; $display("[TB] FAIL after_reset_start lat=%0d res=%h required 16 00000051", lat, res);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_abort();
        int pulses = 0; int lat; logic [31:0] res; logic exc;
        run_mult(32'd3, 32'd4, lat, res, exc);
        @(posedge clock); #1;
        data_operandA = 32'd9; data_operandB = 32'd9; ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("[TB] FAIL abort_busy got=%b required=0", busy);
        end
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) pulses++;
        end
        total++;
        if (pulses != 0 || data_result !== 32'd12) begin
            bad++; $display("[TB] FAIL abort_no_rdy pulses=%0d res=%h required 0 0000000C", pulses, data_result);
        end
        ctrl_DIV = 1'b1;
        repeat (3) begin @(posedge clock); #1; end
        ctrl_DIV = 1'b0;
        total++;
        if (busy !== 1'b0 || data_resultRDY !== 1'b0 || data_result !== 32'd12) begin
            bad++; $display("[TB] FAIL div_in_idle busy=%b rdy=%b res=%h required 0 0 0000000C", busy, data_resultRDY, data_result);
        end
    endtask

    task automatic test_priority();
        int lat = -1; logic [31:0] res = '0;
        data_operandA = 32'd2; data_operandB = 32'd3; ctrl_MULT = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (4) begin @(posedge clock); #1; end
        data_operandA = 32'hFFFFFFFC; data_operandB = 32'd5; ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        total++;
        if (busy !== 1'b1) begin
            bad++; $display("[TB] FAIL priority_busy got=%b required=1", busy);
        end
        for (int i = 1; i <= 30; i++) begin
            @(posedge clock); #1;
            if (data_resultRDY) begin lat = i; res = data_result; break; end
        end
        total++;
        if (lat != 16 || res !== 32'hFFFFFFEC) begin
            bad++; $display("[TB] FAIL priority_result lat=%0d res=%h required 16 FFFFFFEC", lat, res);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic [31:0] res; logic exc;
        @(posedge clock); #1;
        run_mult(32'd11, 32'd13, lat, res, exc);
        total++;
        if (lat != 16 || res !== 32'd143) begin
            bad++; $display("[TB] FAIL b2b_first lat=%0d res=%h required 16 0000008F", lat, res);
        end
        run_mult(32'hFFFFFFFE, 32'd50, lat, res, exc);
        total++;
        if (lat != 16 || res !== 32'hFFFFFF9C) begin
            bad++; $display("[TB] FAIL b2b_second lat=%0d res=%h required 16 FFFFFF9C", lat, res);
        end
        @(posedge clock); #1;
        total++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("[TB] FAIL b2b_idle rdy=%b busy=%b required 0 0", data_resultRDY, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_products();
        test_restart();
        test_reset_mid();
        test_abort();
        test_priority();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_radix4_sequencer.md
BOOTH_RADIX4_SEQUENCER -- requirements
Module: booth_radix4_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be even and >= 4.
REQ-002 clock  input  1  rising-edge clock; the only clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 ctrl_MULT  input  1  start pulse, sampled at the rising edge of clock.
REQ-005 ctrl_DIV  input  1  abort request, sampled at the rising edge of clock.
REQ-006 data_operandA  input  WIDTH  multiplicand, two's complement.
REQ-007 data_operandB  input  WIDTH  multiplier, two's complement.
REQ-008 data_result  output  WIDTH  low WIDTH bits of the signed product.
REQ-009 data_exception  output  1  signed overflow flag.
REQ-010 data_resultRDY  output  1  one-cycle completion strobe.
REQ-011 busy  output  1  high while iterating.

Function
REQ-012 The FSM SHALL use states IDLE, RUN and DONE.
REQ-013 When ctrl_MULT=1 at an edge in any state, the block SHALL latch A and B, clear the accumulator and the appended bit q(-1), clear the iteration counter and enter RUN.
REQ-014 In RUN, each edge SHALL perform one radix-4 Booth step on triplet {Q[1],Q[0],q(-1)}: 000/111 -> +0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
REQ-015 Each step SHALL add the partial product to the upper half, then arithmetic-shift the register {ACC,Q,q(-1)} right by 2.
REQ-016 ACC SHALL be WIDTH+2 bits wide, and M SHALL be sign-extended before adding, so that +/-2M never overflows.
REQ-017 RUN SHALL last exactly WIDTH/2 steps (16 for WIDTH=32); the counter SHALL be ceil(log2(WIDTH/2)) bits wide.
REQ-018 The edge that completes the final step SHALL enter DONE; data_resultRDY SHALL be high for exactly the following cycle, and the block SHALL then enter IDLE.
REQ-019 Latency: with ctrl_MULT at edge k, data_resultRDY SHALL be high from edge k+WIDTH/2 to edge k+WIDTH/2+1.
REQ-020 data_result and data_exception SHALL be registered, SHALL update at the edge entering DONE, and SHALL hold until the next DONE or reset.
REQ-021 busy SHALL be 1 in RUN only.
REQ-022 ctrl_MULT=1 during RUN SHALL restart with the new operands; the aborted operation SHALL produce no data_resultRDY.
REQ-023 ctrl_DIV=1 during RUN without ctrl_MULT SHALL return to IDLE with no data_resultRDY and no change to the outputs.
REQ-024 If ctrl_MULT and ctrl_DIV are both 1 at the same edge, ctrl_MULT SHALL take priority.
REQ-025 ctrl_DIV in IDLE or DONE SHALL have no effect.

Reset
REQ-026 reset=1 SHALL immediately force IDLE, with data_result=0, data_exception=0, data_resultRDY=0, busy=0, and the counter and datapath registers at 0.
REQ-027 Reset during RUN SHALL discard the operation; no data_resultRDY SHALL follow reset deassertion.
REQ-028 The first ctrl_MULT edge after reset deassertion SHALL start normally.

Configuration
REQ-029 Macro BOOTH_OVERFLOW_DETECT_EN SHALL select the overflow logic.
REQ-030 With BOOTH_OVERFLOW_DETECT_EN defined, data_exception SHALL be 1 when the upper WIDTH bits of the 2*WIDTH product are not all equal to data_result[WIDTH-1].
REQ-031 Without BOOTH_OVERFLOW_DETECT_EN, data_exception SHALL be tied to 0, with no overflow logic synthesised; all other behaviour SHALL be unchanged.

Verification (WIDTH=32, BOOTH_OVERFLOW_DETECT_EN defined unless noted)
REQ-032 A=7, B=-3, ctrl_MULT pulse at edge 0 -> busy high for 16 cycles; data_resultRDY high for one cycle after edge 16; data_result=0xFFFFFFEB; data_exception=0.
REQ-033 A=0x7FFFFFFF, B=2 -> data_result=0xFFFFFFFE, data_exception=1; rerun without the macro -> data_exception=0.
REQ-034 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1; A=0x80000000, B=1 -> data_result=0x80000000, data_exception=0.
REQ-035 Start 5*5, then ctrl_MULT with A=6, B=-6 at edge 4 -> exactly one data_resultRDY, at edge 20, with data_result=0xFFFFFFDC.
REQ-036 Start 9*9, then reset pulse mid-cycle at cycle 8 -> outputs 0 immediately; no data_resultRDY within 40 cycles.
REQ-037 Start 9*9, then ctrl_DIV at edge 5 -> busy drops after edge 5; no data_resultRDY; data_result keeps its prior value.
